// File: rtl/vx_mask_serializer_pkg.sv
// vx_mask_serializer_pkg
//   Shared helpers for the mask serializer and its priority encoder.
//   log2up(n) returns the index width for an n-entry vector. It never
//   returns less than 1, so an N==1 mask still gets a 1-bit index port.
package vx_mask_serializer_pkg;

   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_mask_serializer_prio_enc.sv
// VX_priority_encoder
//   Combinational priority select over data_in.
//   REVERSE=0 picks the lowest set bit; REVERSE=1 picks the highest.
//   MODEL=1 uses the two's-complement lsb trick (x & -x) on a
//   direction-normalised copy. Any other MODEL value uses a linear scan.
//   Ports:
//     data_in    [N-1:0]  candidate bits
//     onehot_out [N-1:0]  selected bit, one-hot (0 when data_in==0)
//     index_out  [LN-1:0] index of selected bit (0 when data_in==0)
//     valid_out           data_in != 0
module VX_priority_encoder
   import vx_mask_serializer_pkg::*;
#(
   parameter int N       = 1,
   parameter int REVERSE = 0,
   parameter int MODEL   = 1
) (
   input  logic [N-1:0]           data_in,
   output logic [N-1:0]           onehot_out,
   output logic [log2up(N)-1:0]   index_out,
   output logic                   valid_out
);
   localparam int LN = log2up(N);

   if (MODEL == 1) begin : g_arith
      logic [N-1:0] src, lsb;
      // Mirror the vector for REVERSE so one "lowest bit" path serves both directions.
      always_comb begin
         src = '0;
         for (int i = 0; i < N; i++)
            src[i] = (REVERSE != 0) ? data_in[N-1-i] : data_in[i];
      end
      assign lsb = src & (~src + N'(1));
      always_comb begin
         onehot_out = '0;
         for (int i = 0; i < N; i++)
            onehot_out[i] = (REVERSE != 0) ? lsb[N-1-i] : lsb[i];
      end
   end else begin : g_scan
      // Last write wins: scan toward the preferred end.
      always_comb begin
         onehot_out = '0;
         for (int i = 0; i < N; i++) begin
            if (REVERSE != 0) begin
               if (data_in[i]) begin
                  onehot_out    = '0;
                  onehot_out[i] = 1'b1;
               end
            end else if (data_in[N-1-i]) begin
               onehot_out        = '0;
               onehot_out[N-1-i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      index_out = '0;
      for (int i = 0; i < N; i++)
         if (onehot_out[i]) index_out = LN'(i);
   end

   assign valid_out = |data_in;

endmodule

// File: rtl/vx_mask_serializer.sv
// vx_mask_serializer
//   Takes an N-bit mask plus tag over valid/ready. Emits one beat per set
//   bit, lowest index first, or highest first when REVERSE=1. The last beat
//   of a mask can overlap the acceptance of the next mask, so there is no
//   bubble between masks. A zero mask is accepted and dropped.
//   Ports:
//     clk, reset_n           clock, synchronous active-low reset
//     valid_in / ready_in    mask handshake (ready_in is comb on ready_out)
//     mask_in, tag_in        request mask and its tag
//     valid_out / ready_out  beat handshake
//     index_out, onehot_out  selected bit of the pending mask
//     tag_out                tag of the mask being serialized
//     last_out               beat carries the final set bit of its mask
module vx_mask_serializer
   import vx_mask_serializer_pkg::*;
#(
   parameter int N       = 4,
   parameter int REVERSE = 0,
   parameter int DATAW   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 valid_in,
   output logic                 ready_in,
   input  logic [N-1:0]         mask_in,
   input  logic [DATAW-1:0]     tag_in,
   output logic                 valid_out,
   input  logic                 ready_out,
   output logic [log2up(N)-1:0] index_out,
   output logic [N-1:0]         onehot_out,
   output logic [DATAW-1:0]     tag_out,
   output logic                 last_out
);
   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     pending_q, pending_d;
   logic [DATAW-1:0] tag_q, tag_d;
   logic             enc_valid;
   logic             busy, fire_in, fire_out;

   VX_priority_encoder #(
      .N       (N),
      .REVERSE (REVERSE),
      .MODEL   (1)
   ) u_enc (
      .data_in    (pending_q),
      .onehot_out (onehot_out),
      .index_out  (index_out),
      .valid_out  (enc_valid)
   );

   assign busy      = (state_q == BUSY);
   assign valid_out = busy;
   assign tag_out   = tag_q;
   assign last_out  = busy && ((pending_q & ~onehot_out) == '0);
   // Held low during reset so nothing is accepted while the block clears.
   assign ready_in  = reset_n && (!busy || (ready_out && last_out));
   assign fire_in   = valid_in && ready_in;
   assign fire_out  = valid_out && ready_out;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      tag_d     = tag_q;
      if (fire_out) begin
         pending_d = pending_q & ~onehot_out;
         if (last_out) state_d = IDLE;
      end
      // A new mask overrides the retire above. A zero mask falls through
      // and leaves (or returns) the block in IDLE.
      if (fire_in && (mask_in != '0)) begin
         pending_d = mask_in;
         tag_d     = tag_in;
         state_d   = BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         tag_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         tag_q     <= tag_d;
      end
   end

   a_busy_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
      busy |-> (pending_q != '0) && enc_valid);

   a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (valid_out && !ready_out) |=> valid_out && $stable(index_out) &&
      $stable(onehot_out) && $stable(tag_out) && $stable(last_out));

   a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      valid_out |-> $onehot(onehot_out));

endmodule
